// File: rtl/fifo_fwft_reader_pkg.sv
// Shared defaults and width helpers for the FWFT read-side drain controller.
package fifo_fwft_reader_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int SKID_DEPTH_DEF = 3;
  localparam int CNT_W_DEF      = 16;
  localparam int OCC_W_DEF      = $clog2(SKID_DEPTH_DEF + 1);

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_fwft_reader_skid_ring_buffer.sv
// Small circular skid buffer; indices wrap at DEPTH, which need not be a power of two.
module skid_ring_buffer
  import fifo_fwft_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = SKID_DEPTH_DEF,
  parameter int OCC_W  = OCC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [OCC_W-1:0]  occ,
  output logic              full,
  output logic              empty
);

  localparam int IDX_W = idx_width(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic              do_push, do_pop;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  assign empty   = (occ == '0);
  assign full    = (occ == OCC_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full buffer is only taken when a pop frees the slot in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx <= '0;
      wr_idx <= '0;
      occ    <= '0;
    end else if (flush) begin
      rd_idx <= '0;
      wr_idx <= '0;
      occ    <= '0;
    end else begin
      if (do_pop)  rd_idx <= next_idx(rd_idx);
      if (do_push) wr_idx <= next_idx(wr_idx);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_idx] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_idx];

endmodule

// File: rtl/fifo_fwft_reader.sv
// Converts the FIFO's 1-cycle-latency read port into a first-word-fall-through stream,
// issuing reads only against guaranteed skid-buffer credit.
module fifo_fwft_reader
  import fifo_fwft_reader_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SKID_DEPTH = SKID_DEPTH_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic              r_clk,
  input  logic              rst_n,
  input  logic              empty,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic              ren,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              clear,
  output logic [CNT_W-1:0]  words_out,
  output logic              ovf_err
);

  localparam int OCC_W = occ_width(SKID_DEPTH);

  logic [OCC_W-1:0] occ;
  logic [OCC_W:0]   credit_used;
  logic             inflight, drop_next;
  logic             buf_full, buf_empty;
  logic             pop, ret_ok;

  // Credit counts words already buffered plus the one still returning; out_ready is
  // deliberately excluded so there is no combinational consumer-to-FIFO path.
  assign credit_used = {1'b0, occ} + (OCC_W + 1)'(inflight);
  assign ren         = rst_n & ~empty & ~clear & (credit_used < (OCC_W + 1)'(SKID_DEPTH));

  assign out_valid = ~buf_empty;
  assign pop       = out_valid & out_ready;
  assign ret_ok    = rvalid & ~drop_next & ~clear;

  skid_ring_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (SKID_DEPTH),
    .OCC_W  (OCC_W)
  ) u_skid (
    .clk       (r_clk),
    .rst_n     (rst_n),
    .flush     (clear),
    .push      (ret_ok),
    .push_data (rdata),
    .pop       (pop),
    .head_data (out_data),
    .occ       (occ),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight  <= 1'b0;
      drop_next <= 1'b0;
      words_out <= '0;
      ovf_err   <= 1'b0;
    end else begin
      inflight <= ren;
      if (clear && inflight)        drop_next <= 1'b1;
      else if (rvalid || !inflight) drop_next <= 1'b0;
      if (pop) words_out <= words_out + 1'b1;
      if (ret_ok && buf_full && !pop) ovf_err <= 1'b1;
    end
  end

endmodule
